// File: rtl/rob_pkg.sv
// Shared constants and entry layout for the reorder/retire buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rob_pkg;

   localparam int TAG_W  = 4;            // owner-ID width, shared with the register file
   localparam int DATA_W = 16;           // result width, shared with the register file
   localparam int WIDTH  = 4;            // alloc / complete / retire lanes per cycle
   localparam int DEPTH  = 2**TAG_W;     // one entry per tag value
   localparam int REG_W  = 4;            // architectural register index width
   localparam int CNT_W  = TAG_W + 1;    // occupancy must represent 0..DEPTH

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              has_dest;
      logic [REG_W-1:0]  target;
      logic [DATA_W-1:0] value;
   } rob_entry_t;

   // Circular pointer advance; wraps naturally modulo DEPTH.
   function automatic logic [TAG_W-1:0] ptr_add(input logic [TAG_W-1:0] p, input int n);
      return p + TAG_W'(n);
   endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Counts the leading run of retire-ready entries starting at the head (lane 0 = head).
// Latency: purely combinational.
// Backpressure: none; the count is capped at WIDTH by construction.
module rob_retire_select
   import rob_pkg::*;
(
   input  logic [WIDTH-1:0] ready_bits,
   output logic [2:0]       retire_k
);

   logic run;

   // Leading-ones count: stop at the first entry that is not yet done.
   always_comb begin
      retire_k = '0;
      run      = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         run = run & ready_bits[i];
         if (run) begin
            retire_k = retire_k + 3'd1;
         end
      end
   end

endmodule

// File: rtl/reorder_retire_unit.sv
// In-order retirement buffer: allocates in program order, completes out of order, retires oldest done entries.
// Latency: a result completed in cycle N appears on the retirement buses in cycle N+2 at the earliest.
// Backpressure: alloc_ready drops when more than DEPTH-WIDTH entries are live; allocation is then dropped.
// Optional: define ROB_FLUSH_EN to add a synchronous flush input that empties the buffer.
module reorder_retire_unit
   import rob_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
`ifdef ROB_FLUSH_EN
   input  logic                    flush,
`endif
   input  logic [2:0]              alloc_count,
   input  logic [WIDTH-1:0]        alloc_has_dest_flat,
   input  logic [WIDTH*REG_W-1:0]  alloc_target_reg_flat,
   output logic                    alloc_ready,
   output logic [WIDTH*TAG_W-1:0]  alloc_tag_flat,
   input  logic [WIDTH-1:0]        complete_valid_flat,
   input  logic [WIDTH*TAG_W-1:0]  complete_tag_flat,
   input  logic [WIDTH*DATA_W-1:0] complete_data_flat,
   output logic [WIDTH-1:0]        retirement_write_data_enable_flat,
   output logic [WIDTH*REG_W-1:0]  retirement_target_reg_flat,
   output logic [WIDTH*DATA_W-1:0] retirement_write_data_flat,
   output logic [WIDTH*TAG_W-1:0]  instruction_writer_flat,
   output logic [2:0]              retire_count,
   output logic [CNT_W-1:0]        occupancy,
   output logic                    empty,
   output logic                    full
);

   rob_entry_t        entries [DEPTH];
   logic [TAG_W-1:0]  head;
   logic [TAG_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;

   logic              flush_i;
   logic [2:0]        alloc_eff;
   logic              alloc_go;
   logic [WIDTH-1:0]  head_ready;
   logic [2:0]        retire_k;

   logic [TAG_W-1:0]  cmp_tag   [WIDTH];
   logic [DATA_W-1:0] cmp_dat   [WIDTH];
   logic [REG_W-1:0]  alloc_tgt [WIDTH];

   logic [WIDTH-1:0]        ret_en_d;
   logic [WIDTH*REG_W-1:0]  ret_tgt_d;
   logic [WIDTH*DATA_W-1:0] ret_dat_d;
   logic [WIDTH*TAG_W-1:0]  ret_wr_d;

`ifdef ROB_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   // Lane requests above WIDTH are clamped so a stray count can never overrun the free window.
   assign alloc_eff   = (alloc_count > 3'(WIDTH)) ? 3'(WIDTH) : alloc_count;
   assign alloc_ready = (count <= CNT_W'(DEPTH - WIDTH));
   assign alloc_go    = alloc_ready && (alloc_eff != 3'd0);

   assign occupancy = count;
   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));

   // Unpack the flat lane buses; lane 0 occupies the most significant slice.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         cmp_tag[i]   = complete_tag_flat[TAG_W*(WIDTH-1-i) +: TAG_W];
         cmp_dat[i]   = complete_data_flat[DATA_W*(WIDTH-1-i) +: DATA_W];
         alloc_tgt[i] = alloc_target_reg_flat[REG_W*(WIDTH-1-i) +: REG_W];
      end
   end

   // Tags offered to dispatch are simply the next free slots after the tail.
   always_comb begin
      alloc_tag_flat = '0;
      for (int i = 0; i < WIDTH; i++) begin
         alloc_tag_flat[TAG_W*(WIDTH-1-i) +: TAG_W] = ptr_add(tail, i);
      end
   end

   // Retire readiness of the WIDTH oldest slots, lane 0 being the head.
   always_comb begin
      head_ready = '0;
      for (int i = 0; i < WIDTH; i++) begin
         head_ready[i] = entries[ptr_add(head, i)].valid && entries[ptr_add(head, i)].done;
      end
   end

   rob_retire_select u_retire_select (
      .ready_bits (head_ready),
      .retire_k   (retire_k)
   );

   // Next retirement bus contents; lanes beyond the retiring run stay zero.
   always_comb begin
      ret_en_d  = '0;
      ret_tgt_d = '0;
      ret_dat_d = '0;
      ret_wr_d  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (3'(i) < retire_k) begin
            ret_en_d[WIDTH-1-i]                     = entries[ptr_add(head, i)].has_dest;
            ret_tgt_d[REG_W*(WIDTH-1-i) +: REG_W]   = entries[ptr_add(head, i)].target;
            ret_dat_d[DATA_W*(WIDTH-1-i) +: DATA_W] = entries[ptr_add(head, i)].value;
            ret_wr_d[TAG_W*(WIDTH-1-i) +: TAG_W]    = ptr_add(head, i);
         end
      end
   end

   assign count_next = count + CNT_W'(alloc_go ? alloc_eff : 3'd0) - CNT_W'(retire_k);

   // Entry array and pointers: completes first, then retire clears, then allocation into free slots.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         // Ascending lane order makes the highest lane win on duplicate tags.
         for (int l = 0; l < WIDTH; l++) begin
            if (complete_valid_flat[WIDTH-1-l] && entries[cmp_tag[l]].valid) begin
               entries[cmp_tag[l]].done  <= 1'b1;
               entries[cmp_tag[l]].value <= cmp_dat[l];
            end
         end
         for (int i = 0; i < WIDTH; i++) begin
            if (3'(i) < retire_k) begin
               entries[ptr_add(head, i)].valid <= 1'b0;
               entries[ptr_add(head, i)].done  <= 1'b0;
            end
         end
         // The free window after the tail never overlaps a live entry while alloc_ready is high.
         if (alloc_go) begin
            for (int i = 0; i < WIDTH; i++) begin
               if (3'(i) < alloc_eff) begin
                  entries[ptr_add(tail, i)] <= '{valid:    1'b1,
                                                 done:     1'b0,
                                                 has_dest: alloc_has_dest_flat[WIDTH-1-i],
                                                 target:   alloc_tgt[i],
                                                 value:    '0};
               end
            end
            tail <= ptr_add(tail, int'(alloc_eff));
         end
         head  <= ptr_add(head, int'(retire_k));
         count <= count_next;
      end
   end

   // Retirement buses are a single-cycle pulse of what retired at the last edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retirement_write_data_enable_flat <= '0;
         retirement_target_reg_flat        <= '0;
         retirement_write_data_flat        <= '0;
         instruction_writer_flat           <= '0;
         retire_count                      <= '0;
      end else if (flush_i) begin
         retirement_write_data_enable_flat <= '0;
         retirement_target_reg_flat        <= '0;
         retirement_write_data_flat        <= '0;
         instruction_writer_flat           <= '0;
         retire_count                      <= '0;
      end else begin
         retirement_write_data_enable_flat <= ret_en_d;
         retirement_target_reg_flat        <= ret_tgt_d;
         retirement_write_data_flat        <= ret_dat_d;
         instruction_writer_flat           <= ret_wr_d;
         retire_count                      <= retire_k;
      end
   end

endmodule

// File: tb/tb_reorder_retire_unit.sv
// Self-checking bench for reorder_retire_unit: directed scenarios followed by random traffic.
// The reference model is an in-order queue of live instructions keyed by tag.
// Define ROB_FLUSH_EN to also exercise the flush scenario.
`timescale 1ns/1ps
module tb_reorder_retire_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [2:0]  alloc_count;
   logic [3:0]  alloc_has_dest_flat;
   logic [15:0] alloc_target_reg_flat;
   logic        alloc_ready;
   logic [15:0] alloc_tag_flat;
   logic [3:0]  complete_valid_flat;
   logic [15:0] complete_tag_flat;
   logic [63:0] complete_data_flat;
   logic [3:0]  ret_en;
   logic [15:0] ret_tgt;
   logic [63:0] ret_dat;
   logic [15:0] ret_wr;
   logic [2:0]  retire_count;
   logic [4:0]  occupancy;
   logic        empty;
   logic        full;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   reorder_retire_unit dut (
      .clk                               (clk),
      .rst                               (rst),
`ifdef ROB_FLUSH_EN
      .flush                             (flush),
`endif
      .alloc_count                       (alloc_count),
      .alloc_has_dest_flat               (alloc_has_dest_flat),
      .alloc_target_reg_flat             (alloc_target_reg_flat),
      .alloc_ready                       (alloc_ready),
      .alloc_tag_flat                    (alloc_tag_flat),
      .complete_valid_flat               (complete_valid_flat),
      .complete_tag_flat                 (complete_tag_flat),
      .complete_data_flat                (complete_data_flat),
      .retirement_write_data_enable_flat (ret_en),
      .retirement_target_reg_flat        (ret_tgt),
      .retirement_write_data_flat        (ret_dat),
      .instruction_writer_flat           (ret_wr),
      .retire_count                      (retire_count),
      .occupancy                         (occupancy),
      .empty                             (empty),
      .full                              (full)
   );

   // Reference model: live instructions in program order.
   typedef struct {
      logic [3:0]  tag;
      logic        has_dest;
      logic [3:0]  target;
      logic        done;
      logic [15:0] value;
   } ment_t;

   ment_t      q[$];
   logic [3:0] next_tag;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      alloc_count           = 3'd0;
      alloc_has_dest_flat   = 4'd0;
      alloc_target_reg_flat = 16'd0;
      complete_valid_flat   = 4'd0;
      complete_tag_flat     = 16'd0;
      complete_data_flat    = 64'd0;
      flush                 = 1'b0;
   endtask

   task automatic set_alloc(input int n, input logic [3:0] hd, input logic [15:0] tg);
      alloc_count           = 3'(n);
      alloc_has_dest_flat   = hd;
      alloc_target_reg_flat = tg;
   endtask

   task automatic set_cmp(input int lane, input logic [3:0] tag, input logic [15:0] data);
      complete_valid_flat[3-lane]            = 1'b1;
      complete_tag_flat[4*(3-lane) +: 4]     = tag;
      complete_data_flat[16*(3-lane) +: 16]  = data;
   endtask

   // One clock: check state-derived outputs, advance the model, check retirement buses.
   task automatic cycle();
      int          k;
      bit          ready_pre;
      logic [3:0]  en_e;
      logic [15:0] tg_e;
      logic [15:0] wr_e;
      logic [63:0] dt_e;
      ment_t       m;

      check("alloc_ready", alloc_ready, q.size() <= 12);
      check("occupancy", occupancy, q.size());
      check("empty", empty, q.size() == 0);
      check("full", full, q.size() == 16);
      check("alloc_tag", alloc_tag_flat, {next_tag, next_tag + 4'd1, next_tag + 4'd2, next_tag + 4'd3});

      ready_pre = (q.size() <= 12);
      k = 0;
      while (k < 4 && k < q.size() && q[k].done) k++;
      en_e = '0; tg_e = '0; wr_e = '0; dt_e = '0;
      for (int i = 0; i < k; i++) begin
         en_e[3-i]           = q[i].has_dest;
         tg_e[4*(3-i) +: 4]  = q[i].target;
         dt_e[16*(3-i) +: 16] = q[i].value;
         wr_e[4*(3-i) +: 4]  = q[i].tag;
      end
      if (flush) begin
         k = 0; en_e = '0; tg_e = '0; wr_e = '0; dt_e = '0;
      end

      @(posedge clk);
      #1;

      if (flush) begin
         q.delete();
         next_tag = 4'd0;
      end else begin
         for (int l = 0; l < 4; l++) begin
            if (complete_valid_flat[3-l]) begin
               for (int j = 0; j < q.size(); j++) begin
                  if (q[j].tag == complete_tag_flat[4*(3-l) +: 4]) begin
                     m       = q[j];
                     m.done  = 1'b1;
                     m.value = complete_data_flat[16*(3-l) +: 16];
                     q[j]    = m;
                  end
               end
            end
         end
         for (int i = 0; i < k; i++) void'(q.pop_front());
         if (ready_pre && alloc_count != 0) begin
            for (int i = 0; i < int'(alloc_count); i++) begin
               m.tag      = next_tag + 4'(i);
               m.has_dest = alloc_has_dest_flat[3-i];
               m.target   = alloc_target_reg_flat[4*(3-i) +: 4];
               m.done     = 1'b0;
               m.value    = 16'd0;
               q.push_back(m);
            end
            next_tag = next_tag + 4'(alloc_count);
         end
      end

      check("ret_enable", ret_en, en_e);
      check("ret_target", ret_tgt, tg_e);
      check("ret_data", ret_dat, dt_e);
      check("ret_writer", ret_wr, wr_e);
      check("retire_count", retire_count, k);
      idle();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      q.delete();
      next_tag = 4'd0;
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [3:0]  hd;
      logic [15:0] tg;
      logic [3:0]  ctag;

      idle();
      rst      = 1'b1;
      next_tag = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_enable", ret_en, 4'd0);
      check("rst_retire_count", retire_count, 3'd0);
      check("rst_occupancy", occupancy, 5'd0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_alloc_ready", alloc_ready, 1'b1);
      rst = 1'b0;

      // Reset in the middle of traffic with live retirement outputs.
      set_alloc(4, 4'b1111, 16'h5678);
      cycle();
      set_cmp(0, 4'd0, 16'h1111);
      set_cmp(1, 4'd1, 16'h2222);
      cycle();
      set_alloc(2, 4'b1010, 16'h9A00);
      cycle();
      set_alloc(2, 4'b1100, 16'hBC00);
      rst = 1'b1;
      @(posedge clk);
      #1;
      q.delete();
      next_tag = 4'd0;
      check("midrst_enable", ret_en, 4'd0);
      check("midrst_retire_count", retire_count, 3'd0);
      check("midrst_occupancy", occupancy, 5'd0);
      check("midrst_empty", empty, 1'b1);
      check("midrst_alloc_ready", alloc_ready, 1'b1);
      rst = 1'b0;
      idle();

      // Out-of-order completion of the two oldest entries.
      set_alloc(4, 4'b1111, 16'h1234);
      check("t2_alloc_tags", alloc_tag_flat, 16'h0123);
      cycle();
      set_cmp(0, 4'd1, 16'hBBBB);
      set_cmp(1, 4'd0, 16'hAAAA);
      cycle();
      cycle();
      check("t2_enable", ret_en, 4'b1100);
      check("t2_target", ret_tgt, 16'h1200);
      check("t2_data", ret_dat, 64'hAAAA_BBBB_0000_0000);
      check("t2_writer", ret_wr, 16'h0100);
      check("t2_retire_count", retire_count, 3'd2);

      // A younger completion waits for the older one.
      set_cmp(0, 4'd3, 16'h3333);
      cycle();
      cycle();
      check("t3_blocked_count", retire_count, 3'd0);
      check("t3_blocked_occ", occupancy, 5'd2);
      set_cmp(0, 4'd2, 16'h2222);
      cycle();
      cycle();
      check("t3_retire_count", retire_count, 3'd2);
      check("t3_writer", ret_wr, 16'h2300);
      check("t3_enable", ret_en, 4'b1100);
      check("t3_target", ret_tgt, 16'h3400);
      check("t3_data", ret_dat, 64'h2222_3333_0000_0000);

      // Fill to full, refused allocation, then wrap.
      do_reset();
      for (int r = 0; r < 4; r++) begin
         set_alloc(4, 4'b1111, 16'h4321);
         cycle();
      end
      check("t4_full_occ", occupancy, 5'd16);
      check("t4_full", full, 1'b1);
      check("t4_full_ready", alloc_ready, 1'b0);
      set_alloc(4, 4'b1111, 16'hFFFF);
      cycle();
      check("t4_ignored_occ", occupancy, 5'd16);
      for (int l = 0; l < 4; l++) set_cmp(l, 4'(l), 16'(16'h0100 * l + 16'h00C0));
      cycle();
      cycle();
      check("t4_retire_count", retire_count, 3'd4);
      check("t4_ready_again", alloc_ready, 1'b1);
      check("t4_occ_12", occupancy, 5'd12);
      check("t4_wrap_tags", alloc_tag_flat, 16'h0123);
      set_alloc(4, 4'b1111, 16'h1111);
      cycle();
      check("t4_refill_occ", occupancy, 5'd16);

      // A no-dest entry uses a retire lane without a register write.
      do_reset();
      set_alloc(2, 4'b0100, 16'h5600);
      cycle();
      set_cmp(0, 4'd0, 16'h0D0D);
      set_cmp(1, 4'd1, 16'h0E0E);
      cycle();
      cycle();
      check("t5_retire_count", retire_count, 3'd2);
      check("t5_enable", ret_en, 4'b0100);
      check("t5_head_advance", alloc_tag_flat, 16'h2345);

`ifdef ROB_FLUSH_EN
      // Flush beats same-cycle alloc, complete and a pending retirement.
      do_reset();
      set_alloc(3, 4'b1110, 16'h7890);
      cycle();
      set_cmp(0, 4'd0, 16'h7777);
      cycle();
      set_alloc(2, 4'b1100, 16'h1200);
      set_cmp(0, 4'd1, 16'h8888);
      flush = 1'b1;
      cycle();
      check("t6_occ", occupancy, 5'd0);
      check("t6_enable", ret_en, 4'd0);
      check("t6_next_tag", alloc_tag_flat, 16'h0123);
`endif

      // Random traffic against the queue model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         n  = int'($urandom_range(0, 4));
         hd = 4'($urandom);
         tg = 16'($urandom);
         set_alloc(n, hd, tg);
         for (int l = 0; l < 4; l++) begin
            if ($urandom_range(0, 1) == 1) begin
               if (q.size() > 0 && $urandom_range(0, 7) != 0)
                  ctag = q[$urandom_range(0, q.size() - 1)].tag;
               else
                  ctag = 4'($urandom);
               set_cmp(l, ctag, 16'($urandom));
            end
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
